// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer for the single-cycle LEGv8 core: arbitrates ExtIRQ and
// NotAnInstr, drives the PC redirect, the registered cause and the acknowledge pulses.
module exc_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ExtIRQ,
  input  logic       NotAnInstr,
  input  logic       ERet,
  input  logic       Stall,
  output logic       Exc,
  output logic [3:0] EStatus,
  output logic       ExcAck,
  output logic       ExtIAck,
  output logic       InHandler,
  output logic       IrqPending
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [3:0] CAUSE_IRQ = 4'b0001;
  localparam logic [3:0] CAUSE_UND = 4'b0010;

  typedef enum logic [1:0] {ST_RUN, ST_TAKE, ST_HANDLER, ST_RETURN} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_prev_reg;
  logic                   pending_reg;
  logic [GW-1:0]          guard_reg;
  logic [3:0]             estatus_reg;
  logic                   irq_edge;
  logic                   irq_ok;
  logic                   exc_ack;
  logic                   ext_iack;

  assign irq_edge = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
  assign irq_ok   = pending_reg & (guard_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:     if (!Stall && (irq_ok || NotAnInstr)) state_next = ST_TAKE;
      ST_TAKE:    if (!Stall) state_next = ST_HANDLER;
      ST_HANDLER: if (ERet) state_next = ST_RETURN;
      ST_RETURN:  state_next = ST_RUN;
      default:    state_next = ST_RUN;
    endcase
  end

  // Acks are the only outputs allowed to follow Stall combinationally.
  always_comb begin
    Exc       = (state_reg == ST_TAKE);
    InHandler = (state_reg == ST_TAKE) || (state_reg == ST_HANDLER);
    exc_ack   = (state_reg == ST_TAKE) && !Stall;
    ext_iack  = exc_ack && (estatus_reg == CAUSE_IRQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
      pending_reg   <= 1'b0;
      guard_reg     <= '0;
      estatus_reg   <= 4'b0000;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], ExtIRQ};
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
      // A fresh edge in the ack cycle must survive the clear.
      pending_reg   <= irq_edge | (pending_reg & ~ext_iack);

      if (state_reg == ST_HANDLER && ERet) begin
        guard_reg <= GUARD_LOAD;
      end else if (guard_reg != '0) begin
        guard_reg <= guard_reg - GW'(1);
      end

      if (state_reg == ST_RUN && state_next == ST_TAKE) begin
        estatus_reg <= irq_ok ? CAUSE_IRQ : CAUSE_UND;
      end else if (state_reg == ST_HANDLER && ERet) begin
        estatus_reg <= 4'b0000;
      end
    end
  end

  assign EStatus    = estatus_reg;
  assign ExcAck     = exc_ack;
  assign ExtIAck    = ext_iack;
  assign IrqPending = pending_reg;

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Sequential exception/interrupt sequencer for the single-cycle LEGv8 core. It takes the decoder's NotAnInstr and ERet flags and the asynchronous external ExtIRQ line, and arbitrates between the two exception causes. It drives the datapath's exception redirect (Exc), the registered cause (EStatus) and the acknowledge handshakes. It sits between maindec and the PC/exception-register logic and replaces the purely combinational Exc/EStatus generation.

Parameters:
SYNC_STAGES, 2, number of flops synchronizing ExtIRQ into clk (minimum 2).
GUARD_CYCLES, 2, cycles after ERet during which a new IRQ is not taken (width of guard counter = $clog2(GUARD_CYCLES+1)).

Ports:
clk  in  1  core clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
ExtIRQ  in  1  external interrupt request, asynchronous level; request = rising edge after sync.
NotAnInstr  in  1  decoder: current instruction is undefined.
ERet  in  1  decoder: current instruction is ERET.
Stall  in  1  datapath cannot redirect PC this cycle; defers exception entry.
Exc  out  1  redirect PC to exception vector.
EStatus  out  4  registered cause: 0001 ExtIRQ, 0010 NotAnInstr, 0000 none.
ExcAck  out  1  one-cycle pulse: exception entry committed.
ExtIAck  out  1  one-cycle pulse: external IRQ serviced (to device).
InHandler  out  1  core is executing a handler; exceptions masked.
IrqPending  out  1  sticky IRQ pending latch state.

Behaviour:
- Reset (reset=0, async): state RUN, sync chain = 0, pending = 0, guard counter = 0, Exc=0, EStatus=0000, ExcAck=0, ExtIAck=0, InHandler=0. A reset mid-handler abandons the handler and pending IRQ.
- IRQ path: ExtIRQ passes SYNC_STAGES flops; a rising edge on the synchronized signal (sync=1, previous=0) sets pending next cycle. ExtIRQ held high causes no retrigger. Pending clears on the ExtIAck cycle, except that a new sync edge in that same cycle keeps it set (set wins). Latency ExtIRQ→IrqPending = SYNC_STAGES+1 cycles.
- irq_ok = pending & (guard counter == 0).
- States RUN, TAKE, HANDLER, RETURN. Exc=1 only in TAKE; InHandler=1 in TAKE and HANDLER.
- RUN: if Stall=1, stay. Else if irq_ok, go to TAKE with cause=0001. Else if NotAnInstr, go to TAKE with cause=0010. IRQ has priority when both are present. A deferred NotAnInstr is not remembered: the decoder re-presents it. ERet in RUN is ignored.
- TAKE: EStatus = cause, registered on entry. Exc held while Stall=1. On the first cycle with Stall=0: ExcAck=1; ExtIAck=1 iff cause=0001; next state HANDLER.
- HANDLER: EStatus holds the cause. NotAnInstr and IRQ are ignored (no nesting); IRQ edges still set pending. ERet=1 → RETURN.
- RETURN (1 cycle): EStatus ← 0000, guard counter ← GUARD_CYCLES, next state RUN.
- Guard counter decrements by 1 each cycle while nonzero and saturates at 0. It blocks only IRQ, not NotAnInstr.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to Exc/EStatus/InHandler. ExcAck and ExtIAck may depend combinationally on Stall in TAKE.

Test Plan:
- Reset mid-HANDLER: pulse reset low while EStatus=0001 → next edge: all outputs 0, state RUN, IrqPending=0.
- ExtIRQ 0→1 at cycle 0, Stall=0 → IrqPending=1 at cycle 3. Exc=1 and EStatus=0001 at cycle 4 with ExcAck=ExtIAck=1. InHandler=1 from cycle 4. IrqPending=0 at cycle 5.
- NotAnInstr=1 together with pending IRQ → EStatus=0001. After ERet, guard expires, and NotAnInstr=1 → second entry with EStatus=0010 and ExtIAck=0.
- Stall=1 for 3 cycles in TAKE with cause 0010 → Exc=1 for 4 cycles. ExcAck is a single pulse on the 4th cycle.
- In HANDLER, NotAnInstr=1 and an ExtIRQ edge → no Exc, IrqPending=1. ERet → RETURN (EStatus=0000), then 2 guard cycles with Exc=0, then TAKE with cause 0001.
- ExtIRQ held high for 50 cycles → exactly one ExtIAck pulse. A new edge arriving on the ExtIAck cycle → IrqPending stays 1 and a second entry occurs after the handler.
